tdm_demux_16: RTL and testbench

- Receive-end companion of the team's 16:1 channel multiplexer used as a time-division serialiser.
- Accepts a serial bit stream of 16 slots per frame, one slot per enabled clock, framed by a slot-0 sync strobe.
- Routes slot k to output bit k and presents the completed 16-bit word with a one-cycle valid pulse.
- Detects framing errors and resynchronises without external intervention.

---
 rtl/tdm_demux_16.sv | 85 ++++++++
 tb/tb_tdm_demux_16.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_16.sv
// tdm_demux_16: receive-side TDM deserialiser, 16 slots per frame.
// Ports: clk, rst (sync, active-high), din/en/frame_sync in;
//        dout/dout_valid (completed frame), sel (next slot), frame_err out.
module tdm_demux_16 #(
   parameter int N_CH  = 16,
   parameter int SEL_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             en,
   input  logic             frame_sync,
   output logic [N_CH-1:0]  dout,
   output logic             dout_valid,
   output logic [SEL_W-1:0] sel,
   output logic             frame_err
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);
   localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

   state_t           state_q;
   // Last slot goes straight to dout, so shadow only holds slots 0..N_CH-2.
   logic [N_CH-2:0]  shadow_q;
   logic [N_CH-1:0]  dout_q;
   logic             valid_q;
   logic             err_q;
   logic [SEL_W-1:0] sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         sel_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (en) begin
            unique case (state_q)
               IDLE: begin
                  if (frame_sync) begin
                     shadow_q[0] <= din;
                     sel_q       <= ONE;
                     state_q     <= RUN;
                  end
               end
               RUN: begin
                  if (frame_sync) begin
                     // Sync always restarts at slot 0; mid-frame it is an error.
                     shadow_q[0] <= din;
                     sel_q       <= ONE;
                     if (sel_q != '0) err_q <= 1'b1;
                  end else if (sel_q == '0) begin
                     // Missing sync: drop out and wait for the next one.
                     err_q   <= 1'b1;
                     state_q <= IDLE;
                  end else if (sel_q == LAST) begin
                     dout_q  <= {din, shadow_q};
                     valid_q <= 1'b1;
                     sel_q   <= '0;
                  end else begin
                     shadow_q[sel_q] <= din;
                     sel_q           <= sel_q + ONE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign sel        = sel_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_tdm_demux_16.sv
// tb_tdm_demux_16: scoreboard bench for tdm_demux_16.
// Expected frames are queued as the last slot is driven.
module tb_tdm_demux_16;

   logic        clk;
   logic        rst;
   logic        din;
   logic        en;
   logic        frame_sync;
   logic [15:0] dout;
   logic        dout_valid;
   logic [3:0]  sel;
   logic        frame_err;

   int checks   = 0;
   int failures = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_word;

   tdm_demux_16 dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .en         (en),
      .frame_sync (frame_sync),
      .dout       (dout),
      .dout_valid (dout_valid),
      .sel        (sel),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: every dout_valid must match the queued frame.
   always @(negedge clk) begin
      if (frame_err) err_cnt++;
      if (dout_valid) begin
         valid_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_valid got dout=%h none expected", dout);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (dout !== e) begin
               failures++;
               $display("FAIL sb_dout got %h expected %h", dout, e);
            end
         end
         checks++;
         if (frame_err !== 1'b0) begin
            failures++;
            $display("FAIL sb_valid_and_err both high");
         end
      end
   end

   task automatic step(input logic d, input logic e, input logic fs);
      din        = d;
      en         = e;
      frame_sync = fs;
      @(posedge clk);
      #1;
   endtask

   task automatic gap();
      logic [3:0] s0;
      s0 = sel;
      step(1'($urandom), 1'b0, 1'($urandom));
      checks++;
      if (sel !== s0 || dout_valid !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL gap_hold sel=%0d v=%b e=%b expected sel=%0d v=0 e=0",
                  sel, dout_valid, frame_err, s0);
      end
   endtask

   task automatic send_frame(input logic [15:0] w, input bit gaps);
      for (int k = 0; k < 16; k++) begin
         if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            for (int g = 0; g < n; g++) gap();
         end
         checks++;
         if (sel !== 4'(k)) begin
            failures++;
            $display("FAIL slot_sel got %0d expected %0d", sel, k);
         end
         if (k == 15) exp_q.push_back(w);
         step(w[k], 1'b1, k == 0);
      end
      checks++;
      if (dout_valid !== 1'b1 || dout !== w || sel !== 4'd0) begin
         failures++;
         $display("FAIL frame_done v=%b dout=%h sel=%0d expected v=1 dout=%h sel=0",
                  dout_valid, dout, sel, w);
      end
      last_word = w;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (dout !== 16'h0 || dout_valid !== 1'b0 ||
             frame_err !== 1'b0 || sel !== 4'd0) begin
            failures++;
            $display("FAIL reset dout=%h v=%b e=%b sel=%0d expected all 0",
                     dout, dout_valid, frame_err, sel);
         end
      end
      rst = 1'b0;
      last_word = 16'h0;
   endtask

   task automatic test_single_frame();
      send_frame(16'hA5C3, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (dout_valid !== 1'b0 || dout !== 16'hA5C3) begin
         failures++;
         $display("FAIL single_pulse v=%b dout=%h expected v=0 dout=a5c3",
                  dout_valid, dout);
      end
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_cnt;
      send_frame(16'h1234, 1'b1);
      send_frame(16'hFFFF, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (valid_cnt - v0 !== 2) begin
         failures++;
         $display("FAIL b2b_pulses got %0d expected 2", valid_cnt - v0);
      end
   endtask

   task automatic test_early_sync();
      logic [15:0] w;
      w = 16'h0F0F;
      for (int k = 0; k < 7; k++) step(1'($urandom), 1'b1, k == 0);
      step(w[0], 1'b1, 1'b1);
      checks++;
      if (frame_err !== 1'b1 || sel !== 4'd1 ||
          dout_valid !== 1'b0 || dout !== last_word) begin
         failures++;
         $display("FAIL early_sync e=%b sel=%0d v=%b dout=%h expected e=1 sel=1 v=0 dout=%h",
                  frame_err, sel, dout_valid, dout, last_word);
      end
      for (int k = 1; k < 16; k++) begin
         if (k == 15) exp_q.push_back(w);
         step(w[k], 1'b1, 1'b0);
         if (k == 1) begin
            checks++;
            if (frame_err !== 1'b0) begin
               failures++;
               $display("FAIL early_err_len e=%b expected 0", frame_err);
            end
         end
      end
      checks++;
      if (dout_valid !== 1'b1 || dout !== w) begin
         failures++;
         $display("FAIL early_frame v=%b dout=%h expected v=1 dout=0f0f",
                  dout_valid, dout);
      end
      last_word = w;
   endtask

   task automatic test_missing_sync();
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (frame_err !== 1'b1 || sel !== 4'd0 || dout !== last_word) begin
         failures++;
         $display("FAIL miss_sync e=%b sel=%0d dout=%h expected e=1 sel=0 dout=%h",
                  frame_err, sel, dout, last_word);
      end
      for (int k = 0; k < 16; k++) begin
         step(1'($urandom), 1'b1, 1'b0);
         checks++;
         if (sel !== 4'd0 || frame_err !== 1'b0 || dout_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_slot sel=%0d e=%b v=%b expected 0 0 0",
                     sel, frame_err, dout_valid);
         end
      end
      send_frame(16'h8001, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [15:0] w;
      send_frame(16'h5555, 1'b0);
      w = 16'h3C3C;
      for (int k = 0; k < 9; k++) step(w[k], 1'b1, k == 0);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      checks++;
      if (dout !== 16'h0 || sel !== 4'd0 ||
          dout_valid !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset dout=%h sel=%0d v=%b e=%b expected 0",
                  dout, sel, dout_valid, frame_err);
      end
      send_frame(16'h00FF, 1'b0);
   endtask

   initial begin
      rst        = 1'b1;
      din        = 1'b0;
      en         = 1'b0;
      frame_sync = 1'b0;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_early_sync();
      test_missing_sync();
      test_reset_mid();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0 || valid_cnt != 7) begin
         failures++;
         $display("FAIL sb_drain left=%0d pulses=%0d expected left=0 pulses=7",
                  exp_q.size(), valid_cnt);
      end
      checks++;
      if (err_cnt != 2) begin
         failures++;
         $display("FAIL err_total got %0d expected 2", err_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
